// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the configurable UART blocks (uart_rx_cfg today,
//   uart_tx_cfg later).
//   - rx_state_t / ST_* : receiver FSM state encoding
//   - PARITY_*          : values for the PARITY parameter
//   - majority3()       : 2-of-3 vote used for the mid-bit samples
// ---------------------------------------------------------------------------
package uart_pkg;

  // State encoding is kept as plain constants so that older netlists and
  // debug scripts that decode the raw 3-bit state keep working.
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Programmable divider producing the oversample tick for the UART.
//   One tick every baud_div+1 clocks while en is high; held idle otherwise.
//   Ports:
//     clock     in   system clock
//     reset_n   in   asynchronous active-low reset
//     en        in   divider enable; low parks the counter at zero
//     baud_div  in   clocks per tick minus 1, sampled at each reload
//     tick      out  single-cycle tick pulse
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  // Down-counter: the tick fires when the count is zero, and the counter is
  // reloaded from baud_div in that same cycle. A new divisor therefore only
  // takes effect from the next tick period onward.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (!en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == '0) begin
      cnt_reg <= baud_div;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tick = en && (cnt_reg == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//   Configurable RS232 receiver: DATA_BITS data bits (LSB first), optional
//   even/odd parity, 1 or 2 stop bits, OVERSAMPLE ticks per bit with a
//   3-sample majority vote around mid-bit, and a valid/ready word output.
//   Ports:
//     clock       in   system clock
//     reset_n     in   asynchronous active-low reset
//     rx          in   serial line (idle high), asynchronous to clock
//     rx_en       in   receiver enable; low aborts any partial frame
//     baud_div    in   clocks per oversample tick minus 1
//     rx_data     out  received word, stable while rx_valid
//     rx_valid    out  word available
//     rx_ready    in   consumer accepts when rx_valid && rx_ready
//     parity_err  out  parity status of the held word
//     frame_err   out  a stop bit of the held word was sampled low
//     break_det   out  every data/parity/stop bit of the held word was 0
//     overrun     out  1-cycle pulse: a word was dropped because the
//                      previous one was still unaccepted
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // Sample positions within a bit: the three ticks straddling mid-bit,
  // and the last tick of the bit where non-final bits are committed.
  localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_HI   = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);

  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  // ---------------------------------------------------------------------
  // rx synchroniser (resets to the idle level so no false start is seen)
  // ---------------------------------------------------------------------
  logic rx_meta_reg;
  logic rx_sync_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------
  logic tick;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (rx_en),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  rx_state_t            state_reg,  state_next;
  logic [S_W-1:0]       s_reg,      s_next;
  logic [1:0]           samp_reg,   samp_next;   // samples at S_LO, S_MID
  logic                 bit_reg,    bit_next;    // voted value of current bit
  logic [IDX_W-1:0]     idx_reg,    idx_next;    // data / stop bit index
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 par_reg,    par_next;    // running XOR of data bits
  logic                 perr_reg,   perr_next;
  logic                 ferr_reg,   ferr_next;
  logic                 zero_reg,   zero_next;   // all bits so far were 0
  logic                 done_reg,   done_next;   // frame finished last cycle
  logic                 bit_now;

  // The third sample is the live synchronised value at S_HI, so the vote
  // is usable in the very tick that takes it (needed for the final stop bit).
  assign bit_now = majority3(samp_reg[1], samp_reg[0], rx_sync_reg);

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    samp_next  = samp_reg;
    bit_next   = bit_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    zero_next  = zero_reg;
    done_next  = 1'b0;

    if (!rx_en) begin
      state_next = ST_IDLE;
      s_next     = '0;
    end else if (state_reg == ST_IDLE) begin
      // Falling edge: start a frame and clear the per-frame accumulators.
      if (!rx_sync_reg) begin
        state_next = ST_START;
        s_next     = '0;
        idx_next   = '0;
        par_next   = 1'b0;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        zero_next  = 1'b1;
      end
    end else if (tick) begin
      if (s_reg == S_LAST) begin
        s_next = '0;
      end else begin
        s_next = s_reg + 1'b1;
      end

      if (s_reg == S_LO)  samp_next[0] = rx_sync_reg;
      if (s_reg == S_MID) samp_next[1] = rx_sync_reg;
      if (s_reg == S_HI)  bit_next     = bit_now;

      case (state_reg)
        ST_START: begin
          // A start bit that votes high was only a glitch.
          if (s_reg == S_LAST) begin
            state_next = bit_reg ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (s_reg == S_LAST) begin
            shift_next = {bit_reg, shift_reg[DATA_BITS-1:1]};
            par_next   = par_reg ^ bit_reg;
            zero_next  = zero_reg & ~bit_reg;
            idx_next   = idx_reg + 1'b1;
            if (idx_reg == IDX_DATA_LAST) begin
              idx_next   = '0;
              state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (s_reg == S_LAST) begin
            if (PARITY == PARITY_ODD) begin
              perr_next = ~(par_reg ^ bit_reg);
            end else begin
              perr_next = par_reg ^ bit_reg;
            end
            zero_next  = zero_reg & ~bit_reg;
            state_next = ST_STOP;
          end
        end

        ST_STOP: begin
          // Stop bits are judged at mid-bit; the final one ends the frame
          // right there so a following start edge is not missed.
          if (s_reg == S_HI) begin
            ferr_next = ferr_reg | ~bit_now;
            zero_next = zero_reg & ~bit_now;
            if (idx_reg == IDX_STOP_LAST) begin
              state_next = ST_IDLE;
              s_next     = '0;
              done_next  = 1'b1;
            end
          end else if (s_reg == S_LAST) begin
            idx_next = idx_reg + 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          s_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      samp_reg  <= '0;
      bit_reg   <= 1'b0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      samp_reg  <= samp_next;
      bit_reg   <= bit_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      zero_reg  <= zero_next;
      done_reg  <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output word register with valid/ready handshake
  // ---------------------------------------------------------------------
  // A completed frame is loaded if the holding register is empty or is
  // being emptied in the same cycle; otherwise it is dropped and overrun
  // pulses. The per-frame accumulators may be cleared by a new start edge
  // in this same cycle, but the load sees their pre-clear values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_reg) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= perr_reg;
          frame_err  <= ferr_reg;
          break_det  <= zero_reg;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Five receiver instances with different frame formats, each on its own
//   serial line: 0=8N1, 1=8E1, 2=8O2, 3=5N1, 4=9N1. Frames are written as
//   literal bit vectors, bit i being the line level during bit time i.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [4:0]  rx_l, en_l, rdy_l;
  logic [4:0]  vld, pe, fe, bd, ov;
  logic [7:0]  d0, d1, d2;
  logic [4:0]  d3;
  logic [8:0]  d4;
  logic [8:0]  dat [5];

  always #5 clock = ~clock;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {4'b0, d3};
  assign dat[4] = d4;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[0]), .rx_en(en_l[0]), .baud_div(baud_div),
    .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy_l[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .break_det(bd[0]), .overrun(ov[0]));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_8e1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[1]), .rx_en(en_l[1]), .baud_div(baud_div),
    .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy_l[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .break_det(bd[1]), .overrun(ov[1]));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(2)) u_8o2 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[2]), .rx_en(en_l[2]), .baud_div(baud_div),
    .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy_l[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .break_det(bd[2]), .overrun(ov[2]));

  uart_rx_cfg #(.DATA_BITS(5), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_5n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[3]), .rx_en(en_l[3]), .baud_div(baud_div),
    .rx_data(d3), .rx_valid(vld[3]), .rx_ready(rdy_l[3]), .parity_err(pe[3]),
    .frame_err(fe[3]), .break_det(bd[3]), .overrun(ov[3]));

  uart_rx_cfg #(.DATA_BITS(9), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_9n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[4]), .rx_en(en_l[4]), .baud_div(baud_div),
    .rx_data(d4), .rx_valid(vld[4]), .rx_ready(rdy_l[4]), .parity_err(pe[4]),
    .frame_err(fe[4]), .break_det(bd[4]), .overrun(ov[4]));

  // Accepted words and overrun pulses, sampled mid-cycle.
  int         got_cnt  [5] = '{default: 0};
  int         ov_cnt   [5] = '{default: 0};
  logic [8:0] got_data [5];
  logic       got_pe   [5];
  logic       got_fe   [5];
  logic       got_bd   [5];

  always @(negedge clock) begin
    for (int k = 0; k < 5; k++) begin
      if (vld[k] && rdy_l[k]) begin
        got_cnt[k]++;
        got_data[k] = dat[k];
        got_pe[k]   = pe[k];
        got_fe[k]   = fe[k];
        got_bd[k]   = bd[k];
      end
      if (ov[k]) ov_cnt[k]++;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int line, input logic [15:0] bits, input int n, input int div);
    for (int i = 0; i < n; i++) begin
      rx_l[line] = bits[i];
      cyc((div + 1) * 16);
    end
    rx_l[line] = 1'b1;
  endtask

  task automatic pulse_en(input int line);
    en_l[line] = 1'b0;
    cyc(2);
    en_l[line] = 1'b1;
  endtask

  typedef struct {
    int          line;
    logic [15:0] bits;
    int          nbits;
    logic [8:0]  exp_data;
    logic        exp_pe;
    logic        exp_fe;
    logic        exp_bd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ln;
    int c0;
    int o0;

    //           line  bits      n   data    pe    fe    bd
    vecs[0] = '{0, 16'h034A, 10, 9'h0A5, 1'b0, 1'b0, 1'b0}; // 8N1 0xA5
    vecs[1] = '{1, 16'h040E, 11, 9'h007, 1'b1, 1'b0, 1'b0}; // 8E1 0x07, p=0 (bad)
    vecs[2] = '{1, 16'h060E, 11, 9'h007, 1'b0, 1'b0, 1'b0}; // 8E1 0x07, p=1
    vecs[3] = '{2, 16'h06AA, 12, 9'h055, 1'b0, 1'b1, 1'b0}; // 8O2 0x55, stop2=0
    vecs[4] = '{2, 16'h0EAA, 12, 9'h055, 1'b0, 1'b0, 1'b0}; // 8O2 0x55 clean
    vecs[5] = '{2, 16'h0CAA, 12, 9'h055, 1'b1, 1'b0, 1'b0}; // 8O2 0x55, p=0 (bad)
    vecs[6] = '{0, 16'h0000, 12, 9'h000, 1'b0, 1'b1, 1'b1}; // 8N1 break, 12 bits low
    vecs[7] = '{3, 16'h006C,  7, 9'h016, 1'b0, 1'b0, 1'b0}; // 5N1 0x16
    vecs[8] = '{4, 16'h0746, 11, 9'h1A3, 1'b0, 1'b0, 1'b0}; // 9N1 0x1A3

    reset_n  = 1'b0;
    baud_div = 16'd3;
    rx_l     = '1;
    en_l     = '1;
    rdy_l    = '1;
    cyc(3);

    check("rst_valid", {27'd0, vld}, 32'd0);
    check("rst_flags", {12'd0, pe, fe, bd, ov}, 32'd0);
    check("rst_data8", {24'd0, d0}, 32'd0);
    check("rst_data9", {23'd0, d4}, 32'd0);

    reset_n = 1'b1;
    cyc(5);

    foreach (vecs[i]) begin
      ln = vecs[i].line;
      c0 = got_cnt[ln];
      send(ln, vecs[i].bits, vecs[i].nbits, 3);
      pulse_en(ln);   // drop any frame started by a trailing low level
      cyc(20);
      check($sformatf("v%0d_count", i), got_cnt[ln] - c0, 32'd1);
      check($sformatf("v%0d_data", i),  {23'd0, got_data[ln]}, {23'd0, vecs[i].exp_data});
      check($sformatf("v%0d_parity", i), {31'd0, got_pe[ln]}, {31'd0, vecs[i].exp_pe});
      check($sformatf("v%0d_frame", i),  {31'd0, got_fe[ln]}, {31'd0, vecs[i].exp_fe});
      check($sformatf("v%0d_break", i),  {31'd0, got_bd[ln]}, {31'd0, vecs[i].exp_bd});
      $display("vector %0d line %0d done, data 0x%0h", i, ln, got_data[ln]);
    end

    // Back-to-back 0x11, 0x22 with the consumer stalled.
    rdy_l[0] = 1'b0;
    c0 = got_cnt[0];
    o0 = ov_cnt[0];
    send(0, 16'h0222, 10, 3);
    send(0, 16'h0244, 10, 3);
    cyc(20);
    check("ovr_valid", {31'd0, vld[0]}, 32'd1);
    check("ovr_hold_data", {24'd0, d0}, 32'h11);
    check("ovr_pulses", ov_cnt[0] - o0, 32'd1);
    check("ovr_no_accept", got_cnt[0] - c0, 32'd0);
    rdy_l[0] = 1'b1;
    cyc(1);
    check("ovr_accept_data", {23'd0, got_data[0]}, 32'h11);
    check("ovr_accept_count", got_cnt[0] - c0, 32'd1);
    check("ovr_valid_fall", {31'd0, vld[0]}, 32'd0);
    $display("overrun sequence done, pulses %0d", ov_cnt[0] - o0);

    // Start glitch a quarter of a bit long.
    c0 = got_cnt[0];
    rx_l[0] = 1'b0;
    cyc(16);
    rx_l[0] = 1'b1;
    cyc(64 * 3);
    check("glitch_count", got_cnt[0] - c0, 32'd0);
    check("glitch_valid", {31'd0, vld[0]}, 32'd0);
    $display("glitch sequence done");

    // Reset in the middle of the data bits, then a clean 0x3C.
    send(0, 16'h0278, 4, 3);
    reset_n = 1'b0;
    #2;
    check("midrst_valid", {27'd0, vld}, 32'd0);
    check("midrst_data0", {24'd0, d0}, 32'd0);
    check("midrst_data1", {24'd0, d1}, 32'd0);
    check("midrst_flags", {12'd0, pe, fe, bd, ov}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    c0 = got_cnt[0];
    send(0, 16'h0278, 10, 3);
    cyc(20);
    check("post_rst_count", got_cnt[0] - c0, 32'd1);
    check("post_rst_data", {23'd0, got_data[0]}, 32'h3C);
    check("post_rst_flags", {29'd0, got_pe[0], got_fe[0], got_bd[0]}, 32'd0);
    $display("reset sequence done, data 0x%0h", got_data[0]);

    // Slower rate: baud_div 3 -> 7 between frames.
    baud_div = 16'd7;
    cyc(20);
    c0 = got_cnt[0];
    send(0, 16'h02B4, 10, 7);
    cyc(40);
    check("div7_count", got_cnt[0] - c0, 32'd1);
    check("div7_data", {23'd0, got_data[0]}, 32'h5A);
    check("div7_flags", {29'd0, got_pe[0], got_fe[0], got_bd[0]}, 32'd0);
    $display("baud change sequence done, data 0x%0h", got_data[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
